// File: rtl/fidus_clock_mon_bfm.sv
// Clock monitor: measures period, high and low time of i_mon_clock in i_clock cycles,
// checks the period against EXP_PERIOD +/- TOL, and reports lock, errors and stuck clocks.
module fidus_clock_mon_bfm #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned EXP_PERIOD  = 10,
    parameter int unsigned TOL         = 1,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned STUCK_LIMIT = 64
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_mon_clock,
    input  logic             i_enable,
    input  logic             i_clear_err,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic [CNT_W-1:0] o_low,
    output logic             o_valid,
    output logic             o_err_period,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_locked,
    output logic             o_stuck,
    output logic             o_stuck_level
);

    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ExpP    = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TolP    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] StuckP  = CNT_W'(STUCK_LIMIT);
    localparam logic [RUN_W-1:0] LockP   = RUN_W'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ErrOne  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ErrMax  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {StIdle, StAcq, StMeas, StStuck} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d, low_q, low_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             valid_q, valid_d, err_q, err_d;
    logic             locked_q, locked_d, stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;

    logic             rise, fall, err_inc, period_bad;
    logic [CNT_W-1:0] diff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CntOne;
    endfunction

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;

    // Deviation of the period just ended; larger minus smaller so it never wraps.
    always_comb begin
        diff       = (per_q >= ExpP) ? (per_q - ExpP) : (ExpP - per_q);
        period_bad = (diff > TolP);
    end

    // Synchronizer plus edge-detect flop; keeps running while disabled.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= i_mon_clock;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Next-state, counters, measurement latches and status flags.
    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        period_d    = period_q;
        high_d      = high_q;
        low_d       = low_q;
        run_d       = run_q;
        err_cnt_d   = err_cnt_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        locked_d    = locked_q;
        stuck_d     = stuck_q;
        stuck_lvl_d = stuck_lvl_q;
        err_inc     = 1'b0;

        if (!i_enable) begin
            state_d  = StIdle;
            per_d    = '0;
            hi_d     = '0;
            lo_d     = '0;
            run_d    = '0;
            locked_d = 1'b0;
            stuck_d  = 1'b0;
        end else begin
            per_d = rise ? CntOne : sat_inc(per_q);
            hi_d  = rise ? CntOne : sat_inc(hi_q);
            lo_d  = fall ? CntOne : sat_inc(lo_q);

            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StAcq;
                    end else if (per_q == StuckP) begin
                        state_d     = StStuck;
                        stuck_d     = 1'b1;
                        stuck_lvl_d = sync2_q;
                        locked_d    = 1'b0;
                        run_d       = '0;
                    end
                end
                StAcq, StMeas: begin
                    if (fall) begin
                        high_d = hi_q;
                    end
                    if (rise) begin
                        state_d  = StMeas;
                        period_d = per_q;
                        valid_d  = 1'b1;
                        // Low time is only trusted once a full cycle has been seen.
                        if (state_q == StMeas) begin
                            low_d = lo_q;
                        end
                        if (period_bad) begin
                            err_d    = 1'b1;
                            err_inc  = 1'b1;
                            run_d    = '0;
                            locked_d = 1'b0;
                        end else begin
                            if (run_q != LockP) begin
                                run_d = run_q + 1'b1;
                            end
                            if (run_d == LockP) begin
                                locked_d = 1'b1;
                            end
                        end
                    end else if (per_q == StuckP) begin
                        state_d     = StStuck;
                        stuck_d     = 1'b1;
                        stuck_lvl_d = sync2_q;
                        locked_d    = 1'b0;
                        run_d       = '0;
                    end
                end
                StStuck: begin
                    // The recovering rise only restarts acquisition.
                    if (rise) begin
                        stuck_d = 1'b0;
                        state_d = StAcq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (i_clear_err) begin
            err_cnt_d = err_inc ? ErrOne : '0;
        end else if (err_inc && (err_cnt_q != ErrMax)) begin
            err_cnt_d = err_cnt_q + ErrOne;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            per_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            period_q    <= '0;
            high_q      <= '0;
            low_q       <= '0;
            run_q       <= '0;
            err_cnt_q   <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            period_q    <= period_d;
            high_q      <= high_d;
            low_q       <= low_d;
            run_q       <= run_d;
            err_cnt_q   <= err_cnt_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
            stuck_q     <= stuck_d;
            stuck_lvl_q <= stuck_lvl_d;
        end
    end

    assign o_period      = period_q;
    assign o_high        = high_q;
    assign o_low         = low_q;
    assign o_valid       = valid_q;
    assign o_err_period  = err_q;
    assign o_err_count   = err_cnt_q;
    assign o_locked      = locked_q;
    assign o_stuck       = stuck_q;
    assign o_stuck_level = stuck_lvl_q;

endmodule

// File: tb/tb_fidus_clock_mon_bfm.sv
// Scoreboard bench for fidus_clock_mon_bfm: a waveform-level model predicts every o_valid
// beat; a monitor pops and compares. Directed checks cover reset, stuck, enable and clear.
module tb_fidus_clock_mon_bfm;

    localparam int CNT_W       = 16;
    localparam int ERR_W       = 8;
    localparam int EXP_PERIOD  = 10;
    localparam int TOL         = 1;
    localparam int LOCK_COUNT  = 4;
    localparam int STUCK_LIMIT = 64;
    localparam int ERR_MAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mon = 1'b0;
    logic             en = 1'b1;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] o_period, o_high, o_low;
    logic             o_valid, o_err_period, o_locked, o_stuck, o_stuck_level;
    logic [ERR_W-1:0] o_err_count;

    fidus_clock_mon_bfm #(
        .CNT_W      (CNT_W),
        .ERR_W      (ERR_W),
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_mon_clock  (mon),
        .i_enable     (en),
        .i_clear_err  (clr),
        .o_period     (o_period),
        .o_high       (o_high),
        .o_low        (o_low),
        .o_valid      (o_valid),
        .o_err_period (o_err_period),
        .o_err_count  (o_err_count),
        .o_locked     (o_locked),
        .o_stuck      (o_stuck),
        .o_stuck_level(o_stuck_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int high;
        int low;
        bit chk_low;
        bit err;
        int err_cnt;
        bit locked;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    // Waveform-level model state
    bit acquired;
    int nv, since, cur_h, cur_l, good_run, err_cnt, last_period;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        acquired    = 1'b0;
        nv          = 0;
        since       = 0;
        cur_h       = 0;
        cur_l       = 0;
        good_run    = 0;
        err_cnt     = 0;
        last_period = 0;
    endtask

    // Called on each driven rising edge of the monitored clock.
    task automatic model_rise(input bit clr_hit);
        exp_t e;
        int   d;
        bit   bad_p;
        if (!acquired) begin
            acquired = 1'b1;
            nv = 0;
            if (clr_hit) err_cnt = 0;
        end else if (since > STUCK_LIMIT) begin
            // Stuck was declared; this edge restarts acquisition.
            good_run = 0;
            nv = 0;
            if (clr_hit) err_cnt = 0;
        end else begin
            d = (since > EXP_PERIOD) ? since - EXP_PERIOD : EXP_PERIOD - since;
            bad_p = (d > TOL);
            if (bad_p) begin
                good_run = 0;
                if (err_cnt < ERR_MAX) err_cnt++;
            end else begin
                good_run++;
            end
            if (clr_hit) err_cnt = bad_p ? 1 : 0;
            e.period  = since;
            e.high    = cur_h;
            e.low     = cur_l;
            e.chk_low = (nv > 0);
            e.err     = bad_p;
            e.err_cnt = err_cnt;
            e.locked  = (good_run >= LOCK_COUNT);
            sbq.push_back(e);
            nv++;
            last_period = since;
        end
        since = 0;
        cur_h = 0;
        cur_l = 0;
    endtask

    // Drive lvl for n reference cycles; clr_hit pulses i_clear_err onto the error cycle.
    task automatic seg(input logic lvl, input int n, input bit clr_hit);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0 && lvl && !mon) model_rise(clr_hit);
            mon = lvl;
            clr = clr_hit && (i == 2);
            since++;
            if (lvl) cur_h++;
            else cur_l++;
        end
    endtask

    task automatic cyc(input int h, input int l, input bit c);
        seg(1'b1, h, c);
        seg(1'b0, l, 1'b0);
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (o_err_period && !o_valid) begin
                total++;
                bad++;
                $display("FAIL err_without_valid: got err=1 valid=0, required coincident");
            end
            if (o_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got period %0d, required no valid",
                             o_period);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("period", int'(o_period), mon_e.period);
                    chk("high", int'(o_high), mon_e.high);
                    if (mon_e.chk_low) chk("low", int'(o_low), mon_e.low);
                    chk("err_period", int'(o_err_period), int'(mon_e.err));
                    chk("err_count", int'(o_err_count), mon_e.err_cnt);
                    chk("locked", int'(o_locked), int'(mon_e.locked));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, l;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_period", int'(o_period), 0);
        chk("rst_high", int'(o_high), 0);
        chk("rst_low", int'(o_low), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_err", int'(o_err_period), 0);
        chk("rst_errcnt", int'(o_err_count), 0);
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_stuck", int'(o_stuck), 0);
        chk("rst_stuck_lvl", int'(o_stuck_level), 0);
        rst_n = 1'b1;

        // Clean 5/5 clock
        repeat (8) cyc(5, 5, 1'b0);
        chk("clean_locked", int'(o_locked), 1);

        // Off-frequency, then slightly slow but in tolerance
        repeat (10) cyc(6, 7, 1'b0);
        chk("offfreq_unlocked", int'(o_locked), 0);
        repeat (8) cyc(5, 6, 1'b0);
        chk("p11_locked", int'(o_locked), 1);

        // Random in-tolerance / out-of-tolerance mix
        for (int i = 0; i < 30; i++) begin
            h = 2 + $urandom_range(0, 6);
            l = 2 + $urandom_range(0, 6);
            cyc(h, l, 1'b0);
        end

        // Stuck high, then recovery
        seg(1'b1, 100, 1'b0);
        chk("stuck_set", int'(o_stuck), 1);
        chk("stuck_level", int'(o_stuck_level), 1);
        chk("stuck_unlocked", int'(o_locked), 0);
        seg(1'b0, 5, 1'b0);
        seg(1'b1, 5, 1'b0);
        chk("stuck_cleared", int'(o_stuck), 0);
        seg(1'b0, 5, 1'b0);
        repeat (6) cyc(5, 5, 1'b0);

        // Error counter saturation and clear coincident with an error
        repeat (260) cyc(6, 7, 1'b0);
        chk("errcnt_sat", int'(o_err_count), ERR_MAX);
        cyc(6, 7, 1'b1);
        chk("errcnt_clear_hit", int'(o_err_count), 1);
        cyc(6, 7, 1'b0);
        repeat (6) cyc(5, 5, 1'b0);

        // Asynchronous reset mid-period
        seg(1'b1, 5, 1'b0);
        seg(1'b0, 2, 1'b0);
        chk("sb_empty_pre_reset", sbq.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_period", int'(o_period), 0);
        chk("arst_high", int'(o_high), 0);
        chk("arst_errcnt", int'(o_err_count), 0);
        chk("arst_locked", int'(o_locked), 0);
        model_reset();
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cyc(5, 5, 1'b0);
        chk("recover_locked", int'(o_locked), 1);

        // Enable low while locked
        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        chk("dis_unlocked", int'(o_locked), 0);
        chk("dis_period_held", int'(o_period), last_period);
        chk("dis_stuck", int'(o_stuck), 0);
        en = 1'b1;
        acquired = 1'b0;
        good_run = 0;
        repeat (6) cyc(5, 5, 1'b0);
        chk("reenable_locked", int'(o_locked), 1);

        seg(1'b0, 10, 1'b0);
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
